mem_port_arbiter: RTL

//  Shares one single-port unified memory between the fetch stage (I port) and the

---
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the fetch (I) and load/store (D) ports.
// One transaction is in flight at a time; D wins unless a blocked fetch has aged out.
module mem_port_arbiter #(
   parameter int XLEN     = 64,
   parameter int AW       = 64,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [AW-1:0]     if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [XLEN-1:0]   if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [AW-1:0]     d_addr,
   input  logic [XLEN-1:0]   d_wdata,
   input  logic [XLEN/8-1:0] d_wstrb,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [XLEN-1:0]   d_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [AW-1:0]     mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [XLEN/8-1:0] mem_wstrb,
   input  logic              mem_ready,
   input  logic              mem_rvalid,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              stall_f,
   output logic              stall_m,
   output logic              err_spur
);

   localparam int               AGE_W   = $clog2(MAX_WAIT + 1);
   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_I,
      WAIT_D
   } state_e;

   state_e           state_q, state_d;
   logic [AGE_W-1:0] age_q, age_d;
   logic             err_spur_q, err_spur_d;

   logic idle;
   logic pick_d;
   logic pick_i;

   always_comb begin
      // NOTE: every signal written here gets a default first so no path can infer a latch.
      idle       = 1'b0;
      pick_d     = 1'b0;
      pick_i     = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_wstrb  = '0;
      if_gnt     = 1'b0;
      d_gnt      = 1'b0;
      if_rvalid  = 1'b0;
      d_rvalid   = 1'b0;
      if_rdata   = '0;
      d_rdata    = '0;
      stall_f    = 1'b0;
      stall_m    = 1'b0;
      state_d    = state_q;
      age_d      = age_q;
      err_spur_d = err_spur_q;

      // Reset gates every output so nothing leaks from stale state during the reset cycle.
      idle   = (state_q == IDLE) && !rst;
      pick_d = d_req && !(if_req && (age_q == AGE_MAX));
      pick_i = if_req && !pick_d;

      if (idle && pick_d) begin
         mem_req   = 1'b1;
         mem_we    = d_we;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
         mem_wstrb = d_wstrb;
         d_gnt     = mem_ready;
      end else if (idle && pick_i) begin
         mem_req  = 1'b1;
         mem_addr = if_addr;
         if_gnt   = mem_ready;
      end

      if (!rst) begin
         if_rvalid = (state_q == WAIT_I) && mem_rvalid;
         d_rvalid  = (state_q == WAIT_D) && mem_rvalid;
         if_rdata  = if_rvalid ? mem_rdata : '0;
         d_rdata   = d_rvalid ? mem_rdata : '0;
         stall_f   = (if_req && !if_gnt) || ((state_q == WAIT_I) && !mem_rvalid);
         stall_m   = (d_req && !d_gnt) || ((state_q == WAIT_D) && !mem_rvalid);
      end

      unique case (state_q)
         IDLE: begin
            if (if_gnt)      state_d = WAIT_I;
            else if (d_gnt)  state_d = WAIT_D;
         end
         WAIT_I, WAIT_D: begin
            if (mem_rvalid)  state_d = IDLE;
         end
         default:            state_d = IDLE;
      endcase

      // A response with nothing outstanding (including one left over from before reset).
      if (idle && mem_rvalid) err_spur_d = 1'b1;

      if (!if_req || if_gnt)    age_d = '0;
      else if (age_q != AGE_MAX) age_d = age_q + AGE_W'(1);
   end

   assign err_spur = err_spur_q && !rst;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q    <= IDLE;
         age_q      <= '0;
         err_spur_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         age_q      <= age_d;
         err_spur_q <= err_spur_d;
      end
   end

endmodule
